// File: rtl/divider_pkg.sv
// Shared state encoding and sizing helper for seq_divider and its datapath.
package divider_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t CALC   = 2'd1;
    localparam state_t FINISH = 2'd2;

    // Iteration counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring compare-subtract-shift step of the sequential divider.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {2'b00, divisor};

    // A clear sign bit on the trial difference means remainder >= divisor.
    assign q_bit   = ~diff[WIDTH+1];
    assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/ready/done handshake.
// Optional two's-complement mode is built only when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Handshake: a request is taken on a rising edge where start=1 and ready=1;
    // done is a single-cycle pulse and results hold until the next done.
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             dbz;

    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] num_mag;
    logic [WIDTH-1:0] den_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .divisor (dvs),
        .bit_in  (dvd[WIDTH-1]),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign ready = (state == IDLE);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic num_neg;
    logic den_neg;
    logic neg_q;
    logic neg_r;

    assign num_neg = signed_op & numerator[WIDTH-1];
    assign den_neg = signed_op & denominator[WIDTH-1];
    assign num_mag = num_neg ? -numerator : numerator;
    assign den_mag = den_neg ? -denominator : denominator;
    assign q_fix   = neg_q ? -dvd : dvd;
    assign r_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= num_neg ^ den_neg;
            neg_r <= num_neg;
        end
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign num_mag          = numerator;
    assign den_mag          = denominator;
    assign q_fix            = dvd;
    assign r_fix            = rem[WIDTH-1:0];
`endif

    // dvd shifts the dividend out of its MSB while quotient bits enter at the LSB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            dbz         <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= num_mag;
                        dvs   <= den_mag;
                        dbz   <= (denominator == '0);
                        rem   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    // A zero divisor leaves the magnitude in rem, so r_fix restores the numerator.
                    quotient    <= dbz ? '1 : q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= dbz;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
